// File: rtl/capacitive_touch_scanner.sv
// Capacitive touch scanner: charges all pads through one shared drive pin,
// then times each pad's discharge through a 2-flop synchroniser. Completed
// scans update the readings bus, a self-calibrated per-channel baseline, a
// debounced touched flag and a sticky hit event per channel.
//
// Handshake: there is no valid/ready pairing here; scan_done is a one-cycle
// strobe that is high exactly while freshly updated readings/touched/hit are
// first visible, and recal / hit_clear are level inputs sampled every edge.
module capacitive_touch_scanner #(
  parameter int N_CH          = 9,
  parameter int COUNT_W       = 16,
  parameter int READ_W        = 32,
  parameter int CHARGE_CYCLES = 1024,
  parameter int TIMEOUT       = 4095,
  parameter int THRESH        = 64,
  parameter int DEBOUNCE      = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          sensors_in,
  output logic                     sensors_out,
  input  logic                     recal,
  input  logic [N_CH-1:0]          hit_clear,
  output logic [N_CH*READ_W-1:0]   readings,
  output logic [N_CH-1:0]          touched,
  output logic [N_CH-1:0]          hit,
  output logic                     calibrated,
  output logic                     scan_done,
  output logic [1:0]               state_o
);

  localparam int TMAX    = (CHARGE_CYCLES > TIMEOUT) ? CHARGE_CYCLES : TIMEOUT;
  localparam int TIMER_W = $clog2(TMAX + 1);
  localparam int DBC_W   = $clog2(DEBOUNCE + 1);
  localparam int CMP_W   = COUNT_W + 1;
  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  typedef enum logic [1:0] {
    S_CHARGE  = 2'd0,
    S_MEASURE = 2'd1,
    S_UPDATE  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [TIMER_W-1:0]      timer_q;
  logic [N_CH-1:0]         sync1_q, sync2_q;
  logic [N_CH-1:0]         done_q;
  logic [COUNT_W-1:0]      count_q    [N_CH];
  logic [COUNT_W-1:0]      baseline_q [N_CH];
  logic [DBC_W-1:0]        dbc_q      [N_CH];
  logic [DBC_W-1:0]        dbc_d      [N_CH];
  logic                    sensors_out_q;
  logic [N_CH*READ_W-1:0]  readings_q;
  logic [N_CH-1:0]         touched_q, touched_d;
  logic [N_CH-1:0]         hit_q, hit_set;
  logic                    calibrated_q;
  logic                    scan_done_q;
  logic                    recal_pend_q;

  logic [N_CH-1:0]         done_nx;
  logic                    meas_last;
  logic                    do_cal;
  logic [N_CH-1:0]         raw;
  logic [N_CH-1:0]         toggle;

  assign sensors_out = sensors_out_q;
  assign readings    = readings_q;
  assign touched     = touched_q;
  assign hit         = hit_q;
  assign calibrated  = calibrated_q;
  assign scan_done   = scan_done_q;
  assign state_o     = state_q;

  // Two-flop synchroniser for the asynchronous pad inputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sensors_in;
      sync2_q <= sync1_q;
    end
  end

  // Scan-end detection, touch comparison and debounce next-state.
  always_comb begin
    done_nx   = done_q | ~sync2_q;
    meas_last = (&done_nx) || (timer_q == TIMER_W'(TIMEOUT - 1));
    do_cal    = ~calibrated_q | recal_pend_q;
    raw       = '0;
    toggle    = '0;
    for (int i = 0; i < N_CH; i++) begin
      // One extra bit so baseline + THRESH never wraps.
      raw[i]   = ({1'b0, count_q[i]} > ({1'b0, baseline_q[i]} + CMP_W'(THRESH)));
      dbc_d[i] = '0;
      if (raw[i] != touched_q[i]) begin
        if (dbc_q[i] == DBC_W'(DEBOUNCE - 1)) toggle[i] = 1'b1;
        else                                   dbc_d[i] = dbc_q[i] + DBC_W'(1);
      end
    end
    touched_d = touched_q ^ toggle;
    hit_set   = touched_d & ~touched_q;
  end

  // Scan FSM with all registered outputs and per-channel state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_CHARGE;
      timer_q       <= '0;
      sensors_out_q <= 1'b0;
      readings_q    <= '0;
      touched_q     <= '0;
      hit_q         <= '0;
      calibrated_q  <= 1'b0;
      scan_done_q   <= 1'b0;
      recal_pend_q  <= 1'b0;
      done_q        <= '0;
      for (int i = 0; i < N_CH; i++) begin
        count_q[i]    <= '0;
        baseline_q[i] <= '0;
        dbc_q[i]      <= '0;
      end
    end else begin
      // Drive follows the CHARGE state one cycle later.
      sensors_out_q <= (state_q == S_CHARGE);
      scan_done_q   <= 1'b0;
      recal_pend_q  <= recal_pend_q | recal;
      hit_q         <= hit_q & ~hit_clear;
      case (state_q)
        S_CHARGE: begin
          if (timer_q == TIMER_W'(CHARGE_CYCLES - 1)) begin
            state_q <= S_MEASURE;
            timer_q <= '0;
            done_q  <= '0;
            for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        S_MEASURE: begin
          timer_q <= timer_q + TIMER_W'(1);
          done_q  <= done_nx;
          for (int i = 0; i < N_CH; i++) begin
            if (sync2_q[i] && !done_q[i] && (count_q[i] != COUNT_MAX))
              count_q[i] <= count_q[i] + COUNT_W'(1);
          end
          if (meas_last) begin
            state_q <= S_UPDATE;
            timer_q <= '0;
          end
        end
        S_UPDATE: begin
          state_q      <= S_CHARGE;
          timer_q      <= '0;
          scan_done_q  <= 1'b1;
          // A request arriving during this cycle belongs to the next UPDATE.
          recal_pend_q <= recal;
          for (int i = 0; i < N_CH; i++)
            readings_q[i*READ_W +: READ_W] <= READ_W'(count_q[i]);
          if (do_cal) begin
            calibrated_q <= 1'b1;
            for (int i = 0; i < N_CH; i++) baseline_q[i] <= count_q[i];
          end else begin
            touched_q <= touched_d;
            hit_q     <= (hit_q & ~hit_clear) | hit_set;
            for (int i = 0; i < N_CH; i++) dbc_q[i] <= dbc_d[i];
          end
        end
        default: begin
          state_q <= S_CHARGE;
          timer_q <= '0;
        end
      endcase
    end
  end

endmodule
